// File: rtl/wishbone_classic_controller.sv
// Wishbone classic single-transfer master: one command at a time,
// retry with one-cycle backoff, strobe timeout, registered outputs.
module wishbone_classic_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]              rsp_status_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BACKOFF
    } state_t;

    typedef enum logic [1:0] {
        ST_OK  = 2'b00,
        ST_ERR = 2'b01,
        ST_RTY = 2'b10,
        ST_TMO = 2'b11
    } status_t;

    state_t                state, state_n;
    logic [CW-1:0]         tcnt, tcnt_n, tcnt_inc;
    logic [RW-1:0]         rcnt, rcnt_n;
    logic                  ready_n;
    logic                  cyc_n;
    logic                  we_n;
    logic [ADDR_WIDTH-1:0] adr_n;
    logic [DATA_WIDTH-1:0] dat_n;
    logic [SW-1:0]         sel_n;
    logic                  rsp_valid_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic [1:0]            status_n;

    assign tcnt_inc = tcnt + CW'(1);

    always_comb begin
        state_n     = state;
        tcnt_n      = tcnt;
        rcnt_n      = rcnt;
        we_n        = wb_we_o;
        adr_n       = wb_adr_o;
        dat_n       = wb_dat_o;
        sel_n       = wb_sel_o;
        rsp_valid_n = 1'b0;
        rdata_n     = rsp_rdata_o;
        status_n    = rsp_status_o;
        unique case (state)
            IDLE: begin
                // ready is low for one cycle after reset release
                if (req_ready_o && req_valid_i) begin
                    we_n    = req_we_i;
                    adr_n   = req_addr_i;
                    dat_n   = req_wdata_i;
                    sel_n   = req_sel_i;
                    tcnt_n  = '0;
                    rcnt_n  = '0;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                if (wb_err_i) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    status_n    = ST_ERR;
                    rdata_n     = '0;
                end else if (wb_ack_i) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    status_n    = ST_OK;
                    rdata_n     = wb_we_o ? '0 : wb_dat_i;
                end else if (wb_rty_i) begin
                    if (rcnt == RMAX) begin
                        state_n     = IDLE;
                        rsp_valid_n = 1'b1;
                        status_n    = ST_RTY;
                        rdata_n     = '0;
                    end else begin
                        rcnt_n  = rcnt + RW'(1);
                        tcnt_n  = '0;
                        state_n = BACKOFF;
                    end
                end else if (tcnt_inc == TMAX) begin
                    tcnt_n      = tcnt_inc;
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    status_n    = ST_TMO;
                    rdata_n     = '0;
                end else begin
                    tcnt_n = tcnt_inc;
                end
            end
            BACKOFF: begin
                state_n = ACTIVE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        cyc_n   = (state_n == ACTIVE);
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            tcnt         <= '0;
            rcnt         <= '0;
            req_ready_o  <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_status_o <= 2'b00;
        end else begin
            state        <= state_n;
            tcnt         <= tcnt_n;
            rcnt         <= rcnt_n;
            req_ready_o  <= ready_n;
            wb_cyc_o     <= cyc_n;
            wb_stb_o     <= cyc_n;
            wb_we_o      <= we_n;
            wb_adr_o     <= adr_n;
            wb_dat_o     <= dat_n;
            wb_sel_o     <= sel_n;
            rsp_valid_o  <= rsp_valid_n;
            rsp_rdata_o  <= rdata_n;
            rsp_status_o <= status_n;
        end
    end

endmodule

// File: doc/wishbone_classic_controller.md
WISHBONE_CLASSIC_CONTROLLER -- requirements
Module: wishbone_classic_controller

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH = 32 (address width); DATA_WIDTH = 32 (data width, multiple of 8); TIMEOUT_CYCLES = 16 (strobe cycles allowed before abort, >= 1); MAX_RETRIES = 3 (re-issues allowed after rty, >= 0).
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports are:
- clk_i  in  1  clock, all logic on its rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  command offered
- req_ready_o  out  1  command accepted when high with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  write data
- req_sel_i  in  DATA_WIDTH/8  byte selects
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  DATA_WIDTH  read data
- rsp_status_o  out  2  00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone classic cycle, strobe, write enable
- wb_adr_o  out  ADDR_WIDTH  address
- wb_dat_o  out  DATA_WIDTH  write data
- wb_sel_o  out  DATA_WIDTH/8  byte selects
- wb_dat_i  in  DATA_WIDTH  read data
- wb_ack_i, wb_err_i, wb_rty_i  in  1  cycle terminations
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 FSM states SHALL be IDLE, ACTIVE, BACKOFF.
REQ-005 req_ready_o SHALL be high only in IDLE.
REQ-006 In IDLE, when req_valid_i is high: latch we/addr/wdata/sel, clear the timeout counter and retry counter, and enter ACTIVE with wb_cyc_o = wb_stb_o = 1 on the next cycle.
REQ-007 wb_cyc_o and wb_stb_o SHALL be high exactly in ACTIVE; wb_we_o/adr/dat/sel SHALL hold the latched values throughout a command, including retries.
REQ-008 In ACTIVE, terminations SHALL be sampled each cycle with priority err > ack > rty; the other signals are ignored.
REQ-009 On ack: enter IDLE; next cycle rsp_valid_o = 1, status OK, rsp_rdata_o = wb_dat_i sampled with ack for reads, 0 for writes.
REQ-010 On err: enter IDLE; next cycle rsp_valid_o = 1, status ERR, rsp_rdata_o = 0.
REQ-011 On rty with retry count < MAX_RETRIES: increment the retry count, clear the timeout counter, and enter BACKOFF (cyc/stb low) for exactly one cycle, then ACTIVE.
REQ-012 On rty with retry count == MAX_RETRIES: enter IDLE; rsp_valid_o = 1 with status RETRY_EXHAUSTED and rdata 0.
REQ-013 The timeout counter SHALL count ACTIVE cycles without termination and be $clog2(TIMEOUT_CYCLES+1) bits wide.
REQ-014 When the counter reaches TIMEOUT_CYCLES with no termination: drop cyc/stb and enter IDLE; rsp_valid_o = 1 with status TIMEOUT and rdata 0.
REQ-015 A termination SHALL win over a timeout in the same cycle.
REQ-016 rsp_valid_o SHALL be a single-cycle pulse per accepted command.
REQ-017 rsp_rdata_o and rsp_status_o SHALL hold until the next response.
REQ-018 A new command MAY be accepted in the same cycle that rsp_valid_o is high, since the FSM is already in IDLE.
REQ-019 Terminations sampled in IDLE or BACKOFF SHALL be ignored.

Reset
REQ-020 While rst_ni = 0, asynchronously: state IDLE; all counters 0; wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, wb_sel_o = 0; rsp_valid_o = 0, rsp_rdata_o = 0, rsp_status_o = 00; req_ready_o = 0.
REQ-021 req_ready_o SHALL go high on the first clock edge after rst_ni rises.
REQ-022 Reset during ACTIVE or BACKOFF SHALL abort the command, drop cyc/stb immediately, and emit no response.

Verification
REQ-023 Read at 0x10, device acks in the first strobe cycle with 0xDEADBEEF -> cyc/stb high for 1 cycle; rsp_valid_o 2 cycles after acceptance; rdata 0xDEADBEEF, status 00.
REQ-024 Write 0xA5A5A5A5, sel 0xF, ack after 3 wait states -> cyc/stb high 4 cycles with stable adr/dat/sel/we=1; status 00, rdata 0.
REQ-025 Device asserts rty on every strobe, MAX_RETRIES = 3 -> 4 strobe periods, each separated by one low cycle; status 10.
REQ-026 Device never responds, TIMEOUT_CYCLES = 16 -> cyc/stb high exactly 16 cycles; status 11.
REQ-027 err and ack asserted together -> status 01; then rst_ni pulsed low mid-ACTIVE -> cyc/stb low immediately and no rsp_valid_o.
REQ-028 Back-to-back commands held valid -> second command accepted in the rsp_valid_o cycle of the first; cyc drops for exactly one cycle between them.
